timer_sequencer: RTL



---
 rtl/timer_sequencer_pkg.sv | 31 +++
 rtl/timer_sequencer_if.sv | 27 ++
 rtl/timer_sequencer_tick_detect.sv | 30 +++
 rtl/timer_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the GB timer sequencer.
// Register codes, FSM states and the TAC divider-bit table.
package timer_sequencer_pkg;

    localparam logic [15:0] SYS_RESET_DEF = 16'hD300;
    localparam int          PEND_W_DEF    = 4;

    localparam logic [3:0] REG_DIV  = 4'd4;
    localparam logic [3:0] REG_TIMA = 4'd5;
    localparam logic [3:0] REG_TMA  = 4'd6;
    localparam logic [3:0] REG_TAC  = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        OVF,
        RELOAD
    } state_t;

    function automatic logic [3:0] tac_bit(input logic [1:0] sel);
        logic [3:0] b;
        unique case (sel)
            2'b00:   b = 4'd9;
            2'b01:   b = 4'd3;
            2'b10:   b = 4'd5;
            default: b = 4'd7;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/timer_sequencer_if.sv
// CPU/register-file side bundle of the timer sequencer.
// The master drives instruction reports and MCU writes.
interface timer_sequencer_if;

    logic       iEof;
    logic [2:0] iMcycles;
    logic       iMcuWe;
    logic [3:0] iMcuRegSelect;
    logic [7:0] iMcuWriteData;
    logic [7:0] oDiv;
    logic [7:0] oTima;
    logic [7:0] oModulo;
    logic [7:0] oTac;
    logic       oInterrupt0x50;
    logic       oBusy;

    modport master (
        output iEof, iMcycles, iMcuWe, iMcuRegSelect, iMcuWriteData,
        input  oDiv, oTima, oModulo, oTac, oInterrupt0x50, oBusy
    );

    modport slave (
        input  iEof, iMcycles, iMcuWe, iMcuRegSelect, iMcuWriteData,
        output oDiv, oTima, oModulo, oTac, oInterrupt0x50, oBusy
    );

endinterface

// File: rtl/timer_sequencer_tick_detect.sv
// Falling-edge detector on the TAC-selected, enabled counter bit.
// Fed with next-cycle values so writes and steps are both seen.
module timer_tick_detect
    import timer_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sys,
    input  logic [2:0]  tac,
    output logic        tick
);

    logic level;
    logic level_q;

    always_comb begin
        level = tac[2] & sys[tac_bit(tac[1:0])];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign tick = level_q & ~level;

endmodule

// File: rtl/timer_sequencer.sv
// Replays reported M-cycles against the system counter and
// runs the TIMA overflow / reload sequence with MCU write arbitration.
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter logic [15:0] SYS_RESET = SYS_RESET_DEF,
    parameter int          PEND_W    = PEND_W_DEF
) (
    input  logic             iClock,
    input  logic             iReset,
    timer_sequencer_if.slave bus
);

    localparam int                SUM_W    = PEND_W + 3;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state_q, state_d, run_state;
    logic [15:0]       sys_q, sys_d;
    logic [7:0]        tima_q, tima_d;
    logic [7:0]        tma_q, tma_d;
    logic [2:0]        tac_q, tac_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [SUM_W-1:0]  pend_sum;
    logic              irq_q, irq_d;
    logic [2:0]        eof_cnt;
    logic              wr_div, wr_tima, wr_tma, wr_tac;
    logic              step, tick;

    always_comb begin
        wr_div  = 1'b0;
        wr_tima = 1'b0;
        wr_tma  = 1'b0;
        wr_tac  = 1'b0;
        if (bus.iMcuWe) begin
            unique case (bus.iMcuRegSelect)
                REG_DIV:  wr_div  = 1'b1;
                REG_TIMA: wr_tima = 1'b1;
                REG_TMA:  wr_tma  = 1'b1;
                REG_TAC:  wr_tac  = 1'b1;
                default:  ;
            endcase
        end
    end

    // No step is taken in the RELOAD clock; new work just accumulates.
    always_comb begin
        eof_cnt = bus.iEof ? bus.iMcycles : 3'd0;
        step    = (state_q != RELOAD) &&
                  ((pend_q != '0) || (eof_cnt != 3'd0));
        sys_d   = sys_q;
        if (wr_div) begin
            sys_d = 16'h0000;
        end else if (step) begin
            sys_d = sys_q + 16'd4;
        end
        tac_d    = wr_tac ? bus.iMcuWriteData[2:0] : tac_q;
        tma_d    = wr_tma ? bus.iMcuWriteData : tma_q;
        pend_sum = SUM_W'(pend_q) + SUM_W'(eof_cnt) - SUM_W'(step);
        pend_d   = (pend_sum > SUM_W'(PEND_MAX)) ?
                   PEND_MAX : pend_sum[PEND_W-1:0];
        run_state = (pend_d != '0) ? STEP : IDLE;
    end

    timer_tick_detect u_tick (
        .clk   (iClock),
        .rst_n (iReset),
        .sys   (sys_d),
        .tac   (tac_d),
        .tick  (tick)
    );

    always_comb begin
        state_d = run_state;
        tima_d  = tima_q;
        irq_d   = 1'b0;
        unique case (state_q)
            OVF: begin
                if (wr_tima) begin
                    tima_d = bus.iMcuWriteData;
                end else if (step) begin
                    tima_d  = tma_d;
                    irq_d   = 1'b1;
                    state_d = RELOAD;
                end else begin
                    state_d = OVF;
                end
            end
            RELOAD: begin
                if (tick) begin
                    tima_d = tima_q + 8'd1;
                    if (tima_q == 8'hFF) state_d = OVF;
                end
            end
            default: begin
                if (wr_tima) begin
                    tima_d = bus.iMcuWriteData;
                end else if (tick) begin
                    tima_d = tima_q + 8'd1;
                    if (tima_q == 8'hFF) state_d = OVF;
                end
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= IDLE;
            sys_q   <= SYS_RESET;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sys_q   <= sys_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.oDiv           = sys_q[15:8];
    assign bus.oTima          = tima_q;
    assign bus.oModulo        = tma_q;
    assign bus.oTac           = {5'b11111, tac_q};
    assign bus.oInterrupt0x50 = irq_q;
    assign bus.oBusy          = (pend_q != '0) |
                                ((eof_cnt != 3'd0) & iReset);

endmodule
